// File: rtl/window_wta.sv
// Winner-take-all disparity selection: pipelined minimum search over D cost lanes,
// with a per-line column counter that flags pixels whose search range is truncated.
module window_wta #(
  parameter  int WC    = 7,
  parameter  int WH    = 13,
  parameter  int M     = 650,
  parameter  int D     = 64,
  localparam int NOBIT = $clog2((WC**2/2)*(WH**2)),
  localparam int DBIT  = (D > 2) ? $clog2(D) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [D*NOBIT-1:0]   i_cost,
  input  logic                 i_dval,
  output logic [DBIT-1:0]      o_disp,
  output logic [NOBIT-1:0]     o_cost,
  output logic                 o_border,
  output logic                 o_dval
);

  localparam int L  = $clog2(D) + 1;
  localparam int S  = L - 1;
  localparam int P  = 1 << S;
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  // Heap-ordered tree: node k has children 2k and 2k+1; leaves P..2P-1 are the
  // unregistered input lanes, internal nodes 1..P-1 are registers.
  logic [NOBIT-1:0] t_cost   [1:2*P-1];
  logic [DBIT-1:0]  t_idx    [1:2*P-1];
  logic [NOBIT-1:0] n_cost_q [1:P-1];
  logic [DBIT-1:0]  n_idx_q  [1:P-1];

  logic [S-1:0]     v_q;
  logic [S-1:0]     b_q;
  logic [CW-1:0]    col_q;
  logic [CW-1:0]    col_d;
  logic             border_d;

  always_comb begin
    for (int unsigned k = 1; k < P; k++) begin
      t_cost[k] = n_cost_q[k];
      t_idx[k]  = n_idx_q[k];
    end
    for (int unsigned k = 0; k < P; k++) begin
      if (k < D) t_cost[P+k] = i_cost[k*NOBIT +: NOBIT];
      else       t_cost[P+k] = '1;
      t_idx[P+k] = DBIT'(k);
    end
  end

  // The left child always holds the lower indices, so taking the right child
  // only on a strict win resolves every tie to the lowest disparity.
  always_ff @(posedge i_clk) begin
    for (int unsigned k = 1; k < P; k++) begin
      if (t_cost[2*k+1] < t_cost[2*k]) begin
        n_cost_q[k] <= t_cost[2*k+1];
        n_idx_q[k]  <= t_idx[2*k+1];
      end else begin
        n_cost_q[k] <= t_cost[2*k];
        n_idx_q[k]  <= t_idx[2*k];
      end
    end
  end

  always_comb begin
    col_d = col_q;
    if (i_dval) col_d = (col_q == CW'(M - 1)) ? '0 : col_q + 1'b1;
    border_d = (32'(col_q) < 32'(D - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q    <= '0;
      v_q      <= '0;
      b_q      <= '0;
      o_dval   <= 1'b0;
      o_disp   <= '0;
      o_cost   <= '0;
      o_border <= 1'b0;
    end else begin
      col_q  <= col_d;
      v_q[0] <= i_dval;
      b_q[0] <= border_d;
      for (int unsigned s = 1; s < S; s++) begin
        v_q[s] <= v_q[s-1];
        b_q[s] <= b_q[s-1];
      end
      o_dval   <= v_q[S-1];
      o_border <= b_q[S-1];
      o_disp   <= t_idx[1];
      o_cost   <= t_cost[1];
    end
  end

endmodule
